seq_div12by6: RTL and testbench

- Sequential restoring divider: the inverse of the team's 6x6 array multiplier.
- Divides a 2N-bit dividend (the multiplier's product width) by an N-bit divisor, one quotient bit per clock.
- Returns the 2N-bit quotient and the N-bit remainder.
- Sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake toward its controller.

---
 rtl/arith_pkg.sv | 13 +
 rtl/seq_div12by6_div_step.sv | 28 ++
 rtl/seq_div12by6.sv | 136 +++++++++++++
 tb/tb_seq_div12by6.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: default operand width and the
// sequencer state encoding used by the divider.
package arith_pkg;

    localparam int N = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div12by6_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_step #(
    parameter int N = arith_pkg::N
) (
    input  logic [N:0]   rem,
    input  logic         nbit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_next,
    output logic         qbit
);

    logic [N:0] t_s;
    logic [N:0] dvs_s;

    // Trial subtraction; a set top bit of rem would already exceed any divisor.
    always_comb begin
        t_s   = {rem[N-1:0], nbit};
        dvs_s = {1'b0, divisor};
        qbit  = rem[N] | (t_s >= dvs_s);
        if (qbit) begin
            rem_next = t_s - dvs_s;
        end else begin
            rem_next = t_s;
        end
    end

endmodule

// File: rtl/seq_div12by6.sv
// Sequential restoring divider, 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, with a start/busy/done handshake.
module seq_div12by6
    import arith_pkg::*;
#(
    parameter int N = arith_pkg::N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           busy,
    output logic           done,
    output logic           dz
);

    localparam int             CW   = $clog2(2 * N);
    localparam logic [CW-1:0]  LAST = CW'(2 * N - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    state_t         state_r, state_s;
    logic [CW-1:0]  count_r, count_s;
    logic [2*N-1:0] dvd_r, dvd_s;
    logic [N-1:0]   dvs_r, dvs_s;
    logic [N:0]     rem_r, rem_s;
    logic [2*N-1:0] q_s;
    logic [N-1:0]   r_s;
    logic           busy_s, done_s, dz_s;
    logic [N:0]     step_rem_s;
    logic           step_qbit_s;

    div_step #(.N(N)) u_step (
        .rem      (rem_r),
        .nbit     (dvd_r[2*N-1]),
        .divisor  (dvs_r),
        .rem_next (step_rem_s),
        .qbit     (step_qbit_s)
    );

    // Next-state and next-register logic; done is a pulse so it defaults low.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        dvd_s   = dvd_r;
        dvs_s   = dvs_r;
        rem_s   = rem_r;
        q_s     = q;
        r_s     = r;
        busy_s  = busy;
        done_s  = 1'b0;
        dz_s    = dz;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    if (b != {N{1'b0}}) begin
                        dvd_s   = a;
                        dvs_s   = b;
                        rem_s   = {(N + 1){1'b0}};
                        count_s = {CW{1'b0}};
                        busy_s  = 1'b1;
                        state_s = RUN;
                    end else begin
                        // Zero divisor completes at once with a saturated quotient.
                        q_s     = {(2 * N){1'b1}};
                        r_s     = {N{1'b0}};
                        dz_s    = 1'b1;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = DONE;
                    end
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            RUN: begin
                dvd_s   = {dvd_r[2*N-2:0], step_qbit_s};
                rem_s   = step_rem_s;
                count_s = count_r + ONE;
                if (count_r == LAST) begin
                    q_s     = {dvd_r[2*N-2:0], step_qbit_s};
                    r_s     = step_rem_s[N-1:0];
                    dz_s    = 1'b0;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = DONE;
                end else begin
                    busy_s  = 1'b1;
                    state_s = RUN;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand, partial-remainder, counter and registered output storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            dvd_r   <= {(2 * N){1'b0}};
            dvs_r   <= {N{1'b0}};
            rem_r   <= {(N + 1){1'b0}};
            q       <= {(2 * N){1'b0}};
            r       <= {N{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
        end else begin
            count_r <= count_s;
            dvd_r   <= dvd_s;
            dvs_r   <= dvs_s;
            rem_r   <= rem_s;
            q       <= q_s;
            r       <= r_s;
            busy    <= busy_s;
            done    <= done_s;
            dz      <= dz_s;
        end
    end

endmodule

// File: tb/tb_seq_div12by6.sv
// Scoreboard bench for seq_div12by6: stimulus queues expected results, a
// negedge monitor checks each done pulse against the queue.
module tb_seq_div12by6;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] a;
    logic [5:0]  b;
    logic [11:0] q;
    logic [5:0]  r;
    logic        busy;
    logic        done;
    logic        dz;

    typedef struct {
        logic [11:0] eq;
        logic [5:0]  er;
        logic        edz;
        logic [11:0] ea;
        logic [5:0]  eb;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   done_seen  = 0;

    seq_div12by6 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("q", int'(q), int'(mon_e.eq));
                check("r", int'(r), int'(mon_e.er));
                check("dz", int'(dz), int'(mon_e.edz));
                check("busy_at_done", int'(busy), 0);
                if (!mon_e.edz) begin
                    check("invariant", int'(q) * int'(mon_e.eb) + int'(r), int'(mon_e.ea));
                    check("r_lt_b", int'(r < mon_e.eb), 1);
                end
            end
        end
    end

    task automatic push_exp(input logic [11:0] av, input logic [5:0] bv,
                            input logic [11:0] eq, input logic [5:0] er, input logic edz);
        exp_t e;
        e.eq = eq; e.er = er; e.edz = edz; e.ea = av; e.eb = bv;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [11:0] av, input logic [5:0] bv,
                          input logic [11:0] eq, input logic [5:0] er, input logic edz);
        int cyc;
        int bc;
        push_exp(av, bv, eq, er, edz);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; bc = 0;
        while (!done && cyc < 40) begin
            bc += int'(busy);
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
        check("done_edge", cyc - 1, (bv == 6'd0) ? 0 : 12);
        check("busy_cycles", bc, (bv == 6'd0) ? 0 : 12);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [11:0] ra;
        logic [5:0]  rb;
        rst = 1'b1; start = 1'b0; a = 12'd0; b = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_q", int'(q), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_outputs", int'({q, r, busy, done, dz}), 0);
        end

        // Abort mid-run: no done may follow.
        d0 = done_seen;
        a = 12'd1000; b = 6'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid_run", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_outputs", int'({q, r, busy, done, dz}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);

        // Directed values.
        run_op(12'd1000, 6'd7,  12'd142,  6'd6, 1'b0);
        @(negedge clk);
        run_op(12'd4095, 6'd63, 12'd65,   6'd0, 1'b0);
        @(negedge clk);
        run_op(12'd5,    6'd9,  12'd0,    6'd5, 1'b0);
        @(negedge clk);
        run_op(12'd4095, 6'd1,  12'd4095, 6'd0, 1'b0);
        @(negedge clk);
        run_op(12'd123,  6'd0,  12'hFFF,  6'd0, 1'b1);
        @(negedge clk);
        check("dz_done_drops", int'(done), 0);
        run_op(12'd10,   6'd3,  12'd3,    6'd1, 1'b0);
        repeat (2) @(negedge clk);

        // Start during RUN must be ignored.
        d0 = done_seen;
        push_exp(12'd1000, 6'd7, 12'd142, 6'd6, 1'b0);
        a = 12'd1000; b = 6'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 12'd50; b = 6'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 12'd0; b = 6'd0;
        repeat (25) @(negedge clk);
        check("ignored_start_one_done", done_seen - d0, 1);

        // Back-to-back: second start issued in the DONE cycle.
        run_op(12'd1000, 6'd7,  12'd142, 6'd6, 1'b0);
        run_op(12'd200,  6'd13, 12'd15,  6'd5, 1'b0);
        @(negedge clk);

        // Random sweep, model computed by the bench.
        for (int i = 0; i < 2000; i++) begin
            ra = 12'($urandom_range(0, 4095));
            rb = 6'($urandom_range(0, 63));
            if (rb == 6'd0) run_op(ra, rb, 12'hFFF, 6'd0, 1'b1);
            else            run_op(ra, rb, ra / {6'd0, rb}, 6'(ra % {6'd0, rb}), 1'b0);
            if (i % 3 == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
